dmem_access_arbiter: RTL and testbench

//  - Shares the single-port data memory (async read, sync write) between two masters: A = core datapath, B = loader/debug port.
//  - Fixed priority to A, with a starvation guard for B.
//  - Contains a clear sequencer that walks the whole memory writing zero, so it can be re-initialised without asserting RST.
//  - Sits between the core/loader and the data memory, and drives the memory's ADDR/WD/WE inputs.

---
 rtl/dmem_access_arbiter_pkg.sv | 20 ++
 rtl/dmem_access_arbiter_clr_walker.sv | 77 +++++++
 rtl/dmem_access_arbiter.sv | 147 ++++++++++++++
 tb/tb_dmem_access_arbiter.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_access_arbiter_pkg.sv
// Shared definitions for the data-memory access arbiter.
//  - Default starvation limit for master B.
//  - Clear-sequencer state encodings.
//  - Helper that sizes counters.
package dmem_access_arbiter_pkg;

  localparam int unsigned DMEM_ARB_MAX_WAIT = 4;

  typedef enum logic [1:0] {
    CLR_IDLE  = 2'd0,
    CLR_CLEAR = 2'd1,
    CLR_DONE  = 2'd2
  } clr_state_e;

  // Bits needed to hold values 0..n-1 (at least one bit).
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dmem_access_arbiter_clr_walker.sv
// dmem_clr_walker: clear sequencer for the data memory.
// Walks addresses 0..DEPTH-1 one per cycle. The parent drives a zero write to
// each of these addresses while busy is high.
// Ports:
//  CLK      clock, rising edge
//  RST      asynchronous active-low reset
//  start    start request; only honoured in IDLE
//  busy     sweep in progress (CLEAR state)
//  done     one-cycle pulse after the last clear write (DONE state)
//  accept   start honoured this cycle (IDLE && start)
//  addr     current sweep address
module dmem_clr_walker
  import dmem_access_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DEPTH  = 100
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              accept,
  output logic [ADDR_W-1:0] addr
);

  localparam int unsigned CNT_W = cnt_width(DEPTH);

  clr_state_e       state_q, state_d;
  logic [CNT_W-1:0] clr_cnt_q, clr_cnt_d;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= CLR_IDLE;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    accept    = 1'b0;
    unique case (state_q)
      CLR_IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_d   = CLR_CLEAR;
          clr_cnt_d = '0;
        end
      end
      CLR_CLEAR: begin
        if (clr_cnt_q == CNT_W'(DEPTH - 1)) begin
          state_d   = CLR_DONE;
          clr_cnt_d = '0;
        end else begin
          clr_cnt_d = clr_cnt_q + CNT_W'(1);
        end
      end
      CLR_DONE: begin
        // A start arriving here is dropped, not queued.
        state_d = CLR_IDLE;
      end
      default: begin
        state_d   = CLR_IDLE;
        clr_cnt_d = '0;
      end
    endcase
  end

  assign busy = (state_q == CLR_CLEAR);
  assign done = (state_q == CLR_DONE);
  assign addr = ADDR_W'(clr_cnt_q);

endmodule

// File: rtl/dmem_access_arbiter.sv
// dmem_access_arbiter: shares a single-port data memory (async read, sync
// write) between master A (core datapath) and master B (loader/debug port).
// A has fixed priority. B is forced through after MAX_WAIT consecutive denied
// cycles. A built-in sweep zeroes the whole memory on clr_start.
// Optional feature macro: ACCESS_CNT_EN adds per-master granted-cycle
// counters a_cnt/b_cnt.
// Ports:
//  CLK, RST                    clock (rising), asynchronous active-low reset
//  a_req/a_we/a_addr/a_wd      master A request set; a_gnt grant, a_rd data
//  b_req/b_we/b_addr/b_wd      master B request set; b_gnt grant, b_rd data
//  clr_start                   start clear sweep; clr_busy / clr_done status
//  mem_addr/mem_wd/mem_we      to data memory; mem_rd from data memory
//  a_cnt/b_cnt                 granted-cycle counters (ACCESS_CNT_EN only)
module dmem_access_arbiter
  import dmem_access_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned DEPTH    = 100,
  parameter int unsigned MAX_WAIT = DMEM_ARB_MAX_WAIT
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wd,
  output logic              a_gnt,
  output logic [DATA_W-1:0] a_rd,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wd,
  output logic              b_gnt,
  output logic [DATA_W-1:0] b_rd,
  input  logic              clr_start,
  output logic              clr_busy,
  output logic              clr_done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wd,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rd
`ifdef ACCESS_CNT_EN
  ,
  output logic [15:0]       a_cnt,
  output logic [15:0]       b_cnt
`endif
);

  localparam int unsigned WAIT_W = cnt_width(MAX_WAIT + 1);

  logic              clr_accept;
  logic [ADDR_W-1:0] clr_addr;
  logic              wait_sat;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;

  dmem_clr_walker #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_clr_walker (
    .CLK    (CLK),
    .RST    (RST),
    .start  (clr_start),
    .busy   (clr_busy),
    .done   (clr_done),
    .accept (clr_accept),
    .addr   (clr_addr)
  );

  assign wait_sat = (wait_cnt_q >= WAIT_W'(MAX_WAIT));

  always_comb begin
    b_gnt    = 1'b0;
    a_gnt    = 1'b0;
    mem_we   = 1'b0;
    mem_addr = '0;
    mem_wd   = '0;
    if (clr_busy) begin
      mem_we   = 1'b1;
      mem_addr = clr_addr;
    end else if (b_req && (!a_req || wait_sat)) begin
      b_gnt    = 1'b1;
      mem_we   = b_we;
      mem_addr = b_addr;
      mem_wd   = b_wd;
    end else if (a_req) begin
      a_gnt    = 1'b1;
      mem_we   = a_we;
      mem_addr = a_addr;
      mem_wd   = a_wd;
    end
  end

  // Counts consecutive denied B cycles; frozen while the sweep owns the memory.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (!clr_busy) begin
      if (b_gnt || !b_req) begin
        wait_cnt_d = '0;
      end else if (!wait_sat) begin
        wait_cnt_d = wait_cnt_q + WAIT_W'(1);
      end
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wait_cnt_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end

  assign a_rd = mem_rd;
  assign b_rd = mem_rd;

`ifdef ACCESS_CNT_EN
  logic [15:0] a_cnt_q, a_cnt_d;
  logic [15:0] b_cnt_q, b_cnt_d;

  always_comb begin
    a_cnt_d = a_cnt_q;
    b_cnt_d = b_cnt_q;
    if (clr_accept) begin
      a_cnt_d = '0;
      b_cnt_d = '0;
    end else begin
      if (a_gnt && (a_cnt_q != '1)) a_cnt_d = a_cnt_q + 16'd1;
      if (b_gnt && (b_cnt_q != '1)) b_cnt_d = b_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      a_cnt_q <= '0;
      b_cnt_q <= '0;
    end else begin
      a_cnt_q <= a_cnt_d;
      b_cnt_q <= b_cnt_d;
    end
  end

  assign a_cnt = a_cnt_q;
  assign b_cnt = b_cnt_q;
`endif

endmodule

// File: tb/tb_dmem_access_arbiter.sv
// Bench for dmem_access_arbiter with a behavioural data memory attached.
module tb_dmem_access_arbiter;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        a_req = 1'b0, a_we = 1'b0;
  logic [31:0] a_addr = '0, a_wd = '0;
  logic        b_req = 1'b0, b_we = 1'b0;
  logic [31:0] b_addr = '0, b_wd = '0;
  logic        clr_start = 1'b0;
  logic        a_gnt, b_gnt, clr_busy, clr_done, mem_we;
  logic [31:0] a_rd, b_rd, mem_addr, mem_wd, mem_rd;
`ifdef ACCESS_CNT_EN
  logic [15:0] a_cnt, b_cnt;
`endif

  dmem_access_arbiter #(
    .ADDR_W   (32),
    .DATA_W   (32),
    .DEPTH    (100),
    .MAX_WAIT (4)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .a_req     (a_req),
    .a_we      (a_we),
    .a_addr    (a_addr),
    .a_wd      (a_wd),
    .a_gnt     (a_gnt),
    .a_rd      (a_rd),
    .b_req     (b_req),
    .b_we      (b_we),
    .b_addr    (b_addr),
    .b_wd      (b_wd),
    .b_gnt     (b_gnt),
    .b_rd      (b_rd),
    .clr_start (clr_start),
    .clr_busy  (clr_busy),
    .clr_done  (clr_done),
    .mem_addr  (mem_addr),
    .mem_wd    (mem_wd),
    .mem_we    (mem_we),
    .mem_rd    (mem_rd)
`ifdef ACCESS_CNT_EN
    ,
    .a_cnt     (a_cnt),
    .b_cnt     (b_cnt)
`endif
  );

  always #5 CLK = ~CLK;

  // Behavioural memory: async read, sync write.
  logic [31:0] mem [0:255];
  assign mem_rd = mem[mem_addr[7:0]];
  always @(posedge CLK) if (mem_we) mem[mem_addr[7:0]] <= mem_wd;

  localparam int K_A = 0, K_B = 1, K_DONE = 2;

  typedef struct {
    int          kind;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wd;
    logic        chk_rd;
    logic [31:0] rd;
    int          busy;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   busy_run = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops an expectation whenever the DUT grants or pulses clr_done.
  task automatic pop_and_check(input int kind, input logic [31:0] rd);
    exp_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event: got kind %0d expected none at %0t", kind, $time);
      return;
    end
    e = exp_q.pop_front();
    check("event_kind", 64'(kind), 64'(e.kind));
    if (kind == K_DONE) begin
      check("sweep_len", 64'(busy_run), 64'(e.busy));
    end else begin
      check("mem_addr", 64'(mem_addr), 64'(e.addr));
      check("mem_we", 64'(mem_we), 64'(e.we));
      check("mem_wd", 64'(mem_wd), 64'(e.wd));
      if (e.chk_rd) check("rd_data", 64'(rd), 64'(e.rd));
    end
  endtask

  always @(negedge CLK) begin
    if (!RST) busy_run = 0;
    if (clr_busy) begin
      check("sweep_addr", 64'(mem_addr), 64'(busy_run));
      check("sweep_we_wd", {31'd0, mem_we, mem_wd}, {31'd0, 1'b1, 32'd0});
      check("sweep_nogrant", 64'({a_gnt, b_gnt}), 64'd0);
      busy_run++;
    end
    if (clr_done) begin
      pop_and_check(K_DONE, 32'd0);
      busy_run = 0;
    end
    if (a_gnt && b_gnt) check("dual_grant", 64'd1, 64'd0);
    if (a_gnt) pop_and_check(K_A, a_rd);
    if (b_gnt) pop_and_check(K_B, b_rd);
  end

  // One stimulus cycle; inputs change 1 time unit after the rising edge.
  task automatic cyc(input logic ar, input logic aw, input logic [31:0] aa, input logic [31:0] ad,
                     input logic br, input logic bw, input logic [31:0] ba, input logic [31:0] bd,
                     input logic cs, input int kind, input logic chk, input logic [31:0] rd);
    exp_t e;
    a_req = ar; a_we = aw; a_addr = aa; a_wd = ad;
    b_req = br; b_we = bw; b_addr = ba; b_wd = bd;
    clr_start = cs;
    if (kind == K_A) begin
      e = '{kind: K_A, we: aw, addr: aa, wd: ad, chk_rd: chk, rd: rd, busy: 0};
      exp_q.push_back(e);
    end else if (kind == K_B) begin
      e = '{kind: K_B, we: bw, addr: ba, wd: bd, chk_rd: chk, rd: rd, busy: 0};
      exp_q.push_back(e);
    end
    @(posedge CLK); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, -1, 0, 0);
  endtask

  task automatic push_done(input int busy);
    exp_t e;
    e = '{kind: K_DONE, we: 1'b0, addr: 32'd0, wd: 32'd0, chk_rd: 1'b0, rd: 32'd0, busy: busy};
    exp_q.push_back(e);
  endtask

  // Both masters reading: A at addr 5, B at addr 7.
  task automatic contend(input int kind);
    cyc(1, 0, 32'd5, 0, 1, 0, 32'd7, 0, 0, kind, 1, (kind == K_A) ? 32'hDEAD : 32'hBEEF);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'd0;

    // Reset state
    @(posedge CLK); #1;
    check("rst_busy", 64'(clr_busy), 64'd0);
    check("rst_done", 64'(clr_done), 64'd0);
    check("rst_we", 64'(mem_we), 64'd0);
    check("rst_gnt", 64'({a_gnt, b_gnt}), 64'd0);
    @(posedge CLK); #1;
    RST = 1'b1;

    // A only: write then read back
    cyc(1, 1, 32'd5, 32'hDEAD, 0, 0, 0, 0, 0, K_A, 0, 0);
    cyc(1, 0, 32'd5, 0, 0, 0, 0, 0, 0, K_A, 1, 32'hDEAD);
    // B only: write, B read, A read of same address
    cyc(0, 0, 0, 0, 1, 1, 32'd7, 32'hBEEF, 0, K_B, 0, 0);
    cyc(0, 0, 0, 0, 1, 0, 32'd7, 0, 0, K_B, 1, 32'hBEEF);
    cyc(1, 0, 32'd7, 0, 0, 0, 0, 0, 0, K_A, 1, 32'hBEEF);
    idle(1);

    // Contention: 4:1 pattern, twice
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 4; i++) contend(K_A);
      contend(K_B);
    end
    idle(1);

    // Reset mid-run: starvation count must restart
    for (int i = 0; i < 3; i++) contend(K_A);
    RST = 1'b0;
    #1;
    check("midrst_busy", 64'(clr_busy), 64'd0);
    check("midrst_done", 64'(clr_done), 64'd0);
    check("midrst_we", 64'(mem_we), 64'd0);
    contend(K_A);
    RST = 1'b1;
    for (int i = 0; i < 4; i++) contend(K_A);
    contend(K_B);
    idle(1);

`ifdef ACCESS_CNT_EN
    RST = 1'b0;
    idle(1);
    RST = 1'b1;
    for (int i = 0; i < 7; i++) cyc(1, 0, 32'd5, 0, 0, 0, 0, 0, 0, K_A, 1, 32'hDEAD);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 1, 0, 32'd7, 0, 0, K_B, 1, 32'hBEEF);
    check("a_cnt", 64'(a_cnt), 64'd7);
    check("b_cnt", 64'(b_cnt), 64'd3);
`endif

    // Full clear sweep with both masters requesting during it
    cyc(1, 1, 32'd99, 32'h1234, 0, 0, 0, 0, 0, K_A, 0, 0);
    cyc(1, 0, 32'd99, 0, 0, 0, 0, 0, 0, K_A, 1, 32'h1234);
    push_done(100);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, -1, 0, 0);
`ifdef ACCESS_CNT_EN
    check("a_cnt_clr", 64'(a_cnt), 64'd0);
    check("b_cnt_clr", 64'(b_cnt), 64'd0);
`endif
    for (int i = 0; i < 100; i++) begin
      if (i < 98) cyc(1, 0, 32'd5, 0, 1, 0, 32'd7, 0, 0, -1, 0, 0);
      else        idle(1);
    end
    idle(1);  // DONE cycle
    cyc(1, 0, 32'd99, 0, 0, 0, 0, 0, 0, K_A, 1, 32'd0);
    cyc(1, 0, 32'd5, 0, 0, 0, 0, 0, 0, K_A, 1, 32'd0);
    cyc(0, 0, 0, 0, 1, 0, 32'd7, 0, 0, K_B, 1, 32'd0);
    idle(1);

    // Reset at sweep cycle 40: addresses 40..99 keep their contents
    cyc(1, 1, 32'd39, 32'h39, 0, 0, 0, 0, 0, K_A, 0, 0);
    cyc(1, 1, 32'd40, 32'h40, 0, 0, 0, 0, 0, K_A, 0, 0);
    cyc(1, 1, 32'd99, 32'h99, 0, 0, 0, 0, 0, K_A, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, -1, 0, 0);
    idle(40);
    check("pre_abort_busy", 64'(clr_busy), 64'd1);
    check("pre_abort_addr", 64'(mem_addr), 64'd40);
    RST = 1'b0;
    #1;
    check("abort_busy", 64'(clr_busy), 64'd0);
    check("abort_we", 64'(mem_we), 64'd0);
    idle(1);
    RST = 1'b1;
    cyc(1, 0, 32'd39, 0, 0, 0, 0, 0, 0, K_A, 1, 32'd0);
    cyc(1, 0, 32'd40, 0, 0, 0, 0, 0, 0, K_A, 1, 32'h40);
    cyc(1, 0, 32'd99, 0, 0, 0, 0, 0, 0, K_A, 1, 32'h99);
    idle(110);  // a stray clr_done here would be an unexpected event

    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
